// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse capture front end and its downstream decoder.
package pulse_pkg;

  localparam int DEF_WIDTH_BITS    = 12;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_GLITCH_CYCLES = 3;
  localparam int DEF_FIFO_DEPTH    = 4;

  typedef struct packed {
    logic                      level;
    logic [DEF_WIDTH_BITS-1:0] width;
  } pulse_sym_t;

  typedef enum logic {
    ARM_IDLE = 1'b0,
    ARM_LIVE = 1'b1
  } arm_state_t;

endpackage

// File: rtl/pulse_capture_if.sv
// Symbol output handshake between pulse_capture (master) and the decoder (slave).
interface pulse_capture_if
  import pulse_pkg::*;
#(
  parameter int WIDTH_BITS = DEF_WIDTH_BITS
);

  logic                  sym_valid;
  logic                  sym_ready;
  logic                  sym_level;
  logic [WIDTH_BITS-1:0] sym_width;
  logic                  overflow;

  modport master (
    output sym_valid, sym_level, sym_width, overflow,
    input  sym_ready
  );

  modport slave (
    input  sym_valid, sym_level, sym_width, overflow,
    output sym_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// Small single-clock FIFO; head entry is driven straight from the storage registers.
module sync_fifo #(
  parameter int DATA_W = 13,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign do_pop    = pop_i && !empty_o;
  // A write into a full buffer is allowed when the head leaves in the same cycle.
  assign do_push   = push_i && (!full_o || do_pop);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pulse_capture.sv
// Synchronizes and deglitches a raw pulse line, measures segment widths between
// filtered edges and queues {level, width} symbols for a downstream decoder.
//
//   state    | meaning
//   ARM_IDLE | start time of the current segment unknown; next edge is not reported
//   ARM_LIVE | current segment began at a seen edge; next edge pushes a symbol
module pulse_capture
  import pulse_pkg::*;
#(
  parameter int WIDTH_BITS    = DEF_WIDTH_BITS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int GLITCH_CYCLES = DEF_GLITCH_CYCLES,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             din,
  pulse_capture_if.master  sym
);

  localparam int GW    = $clog2(GLITCH_CYCLES + 1);
  localparam int SYM_W = WIDTH_BITS + 1;
  localparam logic [GW-1:0]         GLITCH_LAST = GW'(GLITCH_CYCLES - 1);
  localparam logic [WIDTH_BITS-1:0] CNT_ONE     = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_BITS-1:0] CNT_MAX     = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_s;
  logic                   level_q, level_d;
  logic [GW-1:0]          stab_q, stab_d;
  logic [WIDTH_BITS-1:0]  cnt_q, cnt_d;
  arm_state_t             arm_q, arm_d;
  logic                   ovf_q, ovf_d;
  logic                   flt_edge;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [SYM_W-1:0]       rd_data;

  assign din_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      stab_q  <= '0;
      cnt_q   <= '0;
      arm_q   <= ARM_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      level_q <= level_d;
      stab_q  <= stab_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    level_d  = level_q;
    stab_d   = stab_q;
    cnt_d    = cnt_q;
    arm_d    = arm_q;
    flt_edge = 1'b0;
    if (!ena) begin
      arm_d = ARM_IDLE;
    end else begin
      if (din_s != level_q) begin
        if (stab_q == GLITCH_LAST) begin
          flt_edge = 1'b1;
          level_d  = ~level_q;
          stab_d   = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end else begin
        stab_d = '0;
      end
      // The count keeps running through rejected excursions; only accepted edges restart it.
      if (flt_edge) begin
        cnt_d = CNT_ONE;
        arm_d = ARM_LIVE;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign push  = flt_edge && (arm_q == ARM_LIVE);
  assign pop   = !fifo_empty && sym.sym_ready;
  assign ovf_d = ovf_q | (push & fifo_full & ~pop);

  sync_fifo #(
    .DATA_W (SYM_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i ({level_q, cnt_q}),
    .pop_i       (pop),
    .rd_data_o   (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign sym.sym_valid = !fifo_empty;
  assign sym.sym_level = rd_data[SYM_W-1];
  assign sym.sym_width = rd_data[WIDTH_BITS-1:0];
  assign sym.overflow  = ovf_q;

endmodule
